// File: rtl/equal_search_if.sv
// Handshake and data bundle for the equal_search key-search unit.
// The abort signal exists only when EQUAL_SEARCH_ABORT_EN is defined.
interface equal_search_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] key;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] seed;
`ifdef EQUAL_SEARCH_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] steps;

    modport master (
`ifdef EQUAL_SEARCH_ABORT_EN
        output abort,
`endif
        output start, key, mask, seed,
        input  busy, done, result, steps
    );

    modport slave (
`ifdef EQUAL_SEARCH_ABORT_EN
        input  abort,
`endif
        input  start, key, mask, seed,
        output busy, done, result, steps
    );
endinterface

// File: rtl/equal_search.sv
// Sequential key search: walks a candidate up from a seed until it matches the key under a mask.
// Optional feature: define EQUAL_SEARCH_ABORT_EN to add an abort input that cancels a search.
module equal_search #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    equal_search_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SEARCH = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] key_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cand_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] steps_q;
    logic             mismatch;
    logic             abort_req;

    // Same xor/or network as the companion comparator, with masked bits forced equal.
    assign mismatch = |((cand_q ^ key_q) & ~mask_q);

`ifdef EQUAL_SEARCH_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    assign bus.busy   = (state == S_SEARCH);
    assign bus.done   = (state == S_DONE);
    assign bus.result = result_q;
    assign bus.steps  = steps_q;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            key_q    <= '0;
            mask_q   <= '0;
            cand_q   <= '0;
            count_q  <= '0;
            result_q <= '0;
            steps_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        key_q   <= bus.key;
                        mask_q  <= bus.mask;
                        cand_q  <= bus.seed;
                        count_q <= '0;
                        state   <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    // Abort outranks a match in the same cycle, leaving result/steps intact.
                    if (abort_req) begin
                        state <= S_IDLE;
                    end else if (!mismatch) begin
                        result_q <= cand_q;
                        steps_q  <= count_q;
                        state    <= S_DONE;
                    end else begin
                        cand_q  <= cand_q + WIDTH'(1);
                        count_q <= count_q + WIDTH'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_equal_search.sv
// Directed self-checking bench for equal_search with hand-computed expectations.
// Abort scenarios are compiled in when EQUAL_SEARCH_ABORT_EN is defined.
module tb_equal_search;
    localparam int WIDTH = 4;
    localparam int LIMIT = 40;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    equal_search_if #(.WIDTH(WIDTH)) bus ();

    equal_search #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start, then waits for done; optionally injects a start with key=1111 at step inj.
    task automatic run(input logic [3:0] k, input logic [3:0] m, input logic [3:0] s, input int inj,
                       output int busy_cycles, output int lat);
        bus.key   = k;
        bus.mask  = m;
        bus.seed  = s;
        bus.start = 1'b1;
        tick();
        bus.start   = 1'b0;
        busy_cycles = 0;
        lat         = 0;
        while (!bus.done && lat < LIMIT) begin
            if (bus.busy) busy_cycles++;
            if (lat == inj) begin
                bus.start = 1'b1;
                bus.key   = 4'hF;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check("no_timeout", 32'(lat < LIMIT), 32'd1);
    endtask

    int bc;
    int lat;
    int pulses;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.key   = 4'hA;
        bus.mask  = 4'h0;
        bus.seed  = 4'h3;
`ifdef EQUAL_SEARCH_ABORT_EN
        bus.abort = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", 32'(bus.result), 32'h0);
        check("rst_steps", 32'(bus.steps), 32'h0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        check("idle_busy", 32'(bus.busy), 32'd0);

        // Basic: 0001 -> 0101 takes four increments, five compares.
        run(4'h5, 4'h0, 4'h1, -1, bc, lat);
        check("basic_busy_cycles", 32'(bc), 32'd5);
        check("basic_done", 32'(bus.done), 32'd1);
        check("basic_busy_at_done", 32'(bus.busy), 32'd0);
        check("basic_result", 32'(bus.result), 32'h5);
        check("basic_steps", 32'(bus.steps), 32'h4);
        tick();
        check("basic_done_one_cycle", 32'(bus.done), 32'd0);
        check("basic_idle_busy", 32'(bus.busy), 32'd0);
        check("basic_result_held", 32'(bus.result), 32'h5);

        // Wrap: 1110,1111,0000,0001,0010.
        run(4'h2, 4'h0, 4'hE, -1, bc, lat);
        check("wrap_result", 32'(bus.result), 32'h2);
        check("wrap_steps", 32'(bus.steps), 32'h4);

        // Seed match: done two edges after the start edge.
        tick();
        run(4'h9, 4'h0, 4'h9, -1, bc, lat);
        check("seed_latency", 32'(lat + 1), 32'd2);
        check("seed_result", 32'(bus.result), 32'h9);
        check("seed_steps", 32'(bus.steps), 32'h0);

        // Mask: low two bits ignored, first hit at 1100.
        tick();
        run(4'hC, 4'h3, 4'h0, -1, bc, lat);
        check("mask_result", 32'(bus.result), 32'hC);
        check("mask_steps", 32'(bus.steps), 32'hC);

        // All-ones mask: the seed matches immediately.
        tick();
        run(4'h0, 4'hF, 4'h7, -1, bc, lat);
        check("maskall_result", 32'(bus.result), 32'h7);
        check("maskall_steps", 32'(bus.steps), 32'h0);

        // Worst case with a stray start mid-search.
        tick();
        run(4'h0, 4'h0, 4'h1, 6, bc, lat);
        check("worst_busy_cycles", 32'(bc), 32'd16);
        check("worst_result", 32'(bus.result), 32'h0);
        check("worst_steps", 32'(bus.steps), 32'hF);

        // Give result a nonzero value, then reset during a long search.
        tick();
        run(4'h5, 4'h0, 4'h1, -1, bc, lat);
        tick();
        bus.key   = 4'h0;
        bus.mask  = 4'h0;
        bus.seed  = 4'h1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_result", 32'(bus.result), 32'h0);
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done || bus.busy) pulses++;
            tick();
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

`ifdef EQUAL_SEARCH_ABORT_EN
        run(4'h6, 4'h0, 4'h4, -1, bc, lat);
        check("pre_abort_result", 32'(bus.result), 32'h6);
        tick();
        bus.key   = 4'h3;
        bus.mask  = 4'h0;
        bus.seed  = 4'h3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", 32'(bus.result), 32'h6);
        check("abort_steps", 32'(bus.steps), 32'h2);
        tick();
        check("abort_no_late_done", 32'(bus.done), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
